sc_ifu: RTL

Instruction-fetch unit for the single-cycle MIPS CPU. It sits directly upstream of the control unit. It holds the PC and fetches from a handshaked instruction memory. It presents one instruction per execute cycle to the control unit and datapath, then loads the next PC from the control unit's `pcsource` selection. It also flags misaligned register-jump targets and counts retired instructions.

---
 rtl/sc_pkg.sv | 8 +
 rtl/sc_ifu_if.sv | 9 +
 rtl/sc_npc.sv | 21 ++
 rtl/sc_ifu.sv | 74 +++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: next-PC select encodings and the fetch-unit state type shared by the IFU files
package sc_pkg;
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;
    typedef enum logic {FETCH, EXEC} ifu_state_t;
endpackage

// File: rtl/sc_ifu_if.sv
// sc_ifu_if: instruction-memory fetch bus (req/addr from the IFU, ready/rdata from memory)
interface sc_ifu_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    modport master (output req, addr, input ready, rdata);
    modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/sc_npc.sv
// sc_npc: combinational next-PC; in pc/imm/ra/pcsource, out p4, npc and jr_mis (jr target not word aligned)
module sc_npc
    import sc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] imm,
    input  logic [31:0] ra,
    input  logic [1:0]  pcsource,
    output logic [31:0] p4,
    output logic [31:0] npc,
    output logic        jr_mis
);
    always_comb begin
        p4 = pc + 32'd4;
        npc = pcsource == PC_SEQ ? p4 :
              pcsource == PC_BR  ? p4 + {{14{imm[15]}}, imm[15:0], 2'b00} :
              pcsource == PC_JR  ? {ra[31:2], 2'b00} :
                                   {p4[31:28], imm, 2'b00};
        jr_mis = pcsource == PC_JR && ra[1:0] != 2'b00;
    end
endmodule

// File: rtl/sc_ifu.sv
// sc_ifu: FETCH/EXEC instruction-fetch unit; clock/reset, imem master bus, pcsource/ra/stall in, inst/inst_valid/pc/p4/icount/misalign out
module sc_ifu
    import sc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    sc_ifu_if.master        imem,
    input  logic [1:0]      pcsource,
    input  logic [31:0]     ra,
    input  logic            stall,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic [31:0]     pc,
    output logic [31:0]     p4,
    output logic [31:0]     icount,
    output logic            misalign
);
    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, icount_q, icount_d, npc;
    logic        mis_q, mis_d, req_q, req_d, val_q, val_d, jr_mis, fire, acc;

    sc_npc u_npc (
        .pc       (pc_q),
        .imm      (inst_q[25:0]),
        .ra       (ra),
        .pcsource (pcsource),
        .p4       (p4),
        .npc      (npc),
        .jr_mis   (jr_mis)
    );

    always_comb begin
        fire     = state_q == EXEC && !stall;
        acc      = req_q && imem.ready;
        state_d  = acc ? EXEC : fire ? FETCH : state_q;
        pc_d     = fire ? npc : pc_q;
        inst_d   = acc ? imem.rdata : inst_q;
        icount_d = icount_q + {31'd0, fire};
        mis_d    = mis_q | (fire & jr_mis);
        req_d    = state_d == FETCH;
        val_d    = state_d == EXEC;
    end

    // req_q stays low through the reset cycles so the first request appears only once reset has been sampled low
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            inst_q   <= 32'd0;
            icount_q <= 32'd0;
            mis_q    <= 1'b0;
            req_q    <= 1'b0;
            val_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            icount_q <= icount_d;
            mis_q    <= mis_d;
            req_q    <= req_d;
            val_q    <= val_d;
        end
    end

    assign imem.req   = req_q;
    assign imem.addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = val_q;
    assign pc         = pc_q;
    assign icount     = icount_q;
    assign misalign   = mis_q;
endmodule
